// File: rtl/pmos_arb_pkg.sv
// rtl/pmos_arb_pkg.sv - shared types and constants for the pmos bus arbiter
//
// Holds the FSM state encoding, default parameter values and the widths of
// the dead-time and hold counters. No ports.
package pmos_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_DEAD = 2'd2
  } arb_state_e;

  localparam int unsigned DEF_N        = 4;
  localparam int unsigned DEF_DEAD_CYC = 2;
  localparam int unsigned DEF_MAX_HOLD = 8;

  // Wide enough for DEAD_CYC up to 15 and MAX_HOLD up to 255.
  localparam int unsigned DEAD_W = 4;
  localparam int unsigned HOLD_W = 8;

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin winner selection
//
// Ports:
//   req_i   [N-1:0]  request vector
//   ptr_i   [W-1:0]  index of the most recent winner; scan starts at ptr_i+1
//   valid_o          at least one request is set
//   idx_o   [W-1:0]  winner index (0 when valid_o is low)
module rr_priority_picker #(
  parameter int unsigned N = 4,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic         valid_o,
  output logic [W-1:0] idx_o
);

  logic [W-1:0] cand;

  // Candidates are visited in order ptr+1, ptr+2, ... wrapping at N; the
  // first set bit wins, so the previous winner has lowest priority.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = W'((32'(ptr_i) + i) % N);
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/pmos_bus_arbiter.sv
// rtl/pmos_bus_arbiter.sv - round-robin break-before-make arbiter for pmos bus drivers
//
// Optional feature macro: PMOS_ARB_TIMEOUT_EN (forced release after MAX_HOLD
// ON cycles when another driver is waiting).
//
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   req      [N-1:0] level requests, one per driver
//   gate_n   [N-1:0] active-low pmos gate drives, at most one low
//   grant    [N-1:0] one-hot owner, equal to ~gate_n
//   busy     high while in ON or DEAD
//   owner    index of the current or most recent owner
module pmos_bus_arbiter
  import pmos_arb_pkg::*;
#(
  parameter int unsigned N        = DEF_N,
  parameter int unsigned DEAD_CYC = DEF_DEAD_CYC,
  parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gate_n,
  output logic [N-1:0]         grant,
  output logic                 busy,
  output logic [$clog2(N)-1:0] owner
);

  localparam int unsigned W = $clog2(N);

  arb_state_e        state_q;
  logic [W-1:0]      ptr_q;
  logic [W-1:0]      owner_q;
  logic [N-1:0]      gate_n_q;
  logic              busy_q;
  logic [DEAD_W-1:0] dead_cnt_q;

  logic              pick_valid;
  logic [W-1:0]      pick_idx;
  logic              release_now;

  rr_priority_picker #(
    .N (N),
    .W (W)
  ) u_picker (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

`ifdef PMOS_ARB_TIMEOUT_EN
  logic [HOLD_W-1:0] hold_cnt_q;
  logic              hold_limit;

  assign hold_limit = (hold_cnt_q == HOLD_W'(MAX_HOLD));
  // In ON, gate_n_q is low only at the owner, so it masks the owner's own
  // request and leaves just the competitors.
  assign release_now = !req[owner_q] || (hold_limit && ((req & gate_n_q) != '0));
`else
  logic unused_max_hold;

  assign unused_max_hold = ^HOLD_W'(MAX_HOLD);
  assign release_now     = !req[owner_q];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= W'(N - 1);
      owner_q    <= '0;
      gate_n_q   <= '1;
      busy_q     <= 1'b0;
      dead_cnt_q <= '0;
`ifdef PMOS_ARB_TIMEOUT_EN
      hold_cnt_q <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            state_q  <= ST_ON;
            gate_n_q <= ~(N'(1) << pick_idx);
            owner_q  <= pick_idx;
            ptr_q    <= pick_idx;
            busy_q   <= 1'b1;
`ifdef PMOS_ARB_TIMEOUT_EN
            hold_cnt_q <= HOLD_W'(1);
`endif
          end
        end
        ST_ON: begin
          if (release_now) begin
            // Gates open at this edge; the dead window starts immediately.
            state_q    <= ST_DEAD;
            gate_n_q   <= '1;
            dead_cnt_q <= DEAD_W'(DEAD_CYC - 1);
          end
`ifdef PMOS_ARB_TIMEOUT_EN
          else if (!hold_limit) begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
`endif
        end
        ST_DEAD: begin
          if (dead_cnt_q == '0) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            dead_cnt_q <= dead_cnt_q - 1'b1;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          gate_n_q <= '1;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign gate_n = gate_n_q;
  assign grant  = ~gate_n_q;
  assign busy   = busy_q;
  assign owner  = owner_q;

endmodule

// File: tb/tb_pmos_bus_arbiter.sv
// tb/tb_pmos_bus_arbiter.sv - self-checking bench for pmos_bus_arbiter
module tb_pmos_bus_arbiter;

  localparam int N        = 4;
  localparam int DEAD_CYC = 2;
  localparam int MAX_HOLD = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N-1:0]         req;
  logic [N-1:0]         gate_n;
  logic [N-1:0]         grant;
  logic                 busy;
  logic [$clog2(N)-1:0] owner;

  always #5 clk = ~clk;

  pmos_bus_arbiter #(
    .N        (N),
    .DEAD_CYC (DEAD_CYC),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .gate_n (gate_n),
    .grant  (grant),
    .busy   (busy),
    .owner  (owner)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: who holds the bus, how many edges since the bus was
  // released, and the round-robin memory.
  int m_owner;      // -1 when nobody owns the bus
  int m_last;
  int m_owner_out;
  int m_since;
  int m_held;

  // Observed-waveform tracking for break-before-make.
  int           high_run;
  int           seen_owner;
  logic [N-1:0] prev_gate;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner     = -1;
    m_last      = N - 1;
    m_owner_out = 0;
    m_since     = DEAD_CYC + 1;
    m_held      = 0;
    high_run    = 0;
    seen_owner  = 0;
    prev_gate   = '1;
  endtask

  task automatic model_edge(input logic [N-1:0] r);
    if (m_owner >= 0) begin
      bit rel = !r[m_owner];
`ifdef PMOS_ARB_TIMEOUT_EN
      if (!rel && m_held == MAX_HOLD && (r & ~(N'(1) << m_owner)) != '0) rel = 1'b1;
`endif
      if (rel) begin
        m_owner = -1;
        m_since = 0;
      end else if (m_held < MAX_HOLD) begin
        m_held++;
      end
    end else begin
      if (m_since < 1000) m_since++;
      // The bus must have been off for DEAD_CYC cycles plus one arbitration edge.
      if (m_since > DEAD_CYC && r != '0) begin
        for (int k = 1; k <= N; k++) begin
          int c = (m_last + k) % N;
          if (r[c] && m_owner < 0) m_owner = c;
        end
        m_last      = m_owner;
        m_owner_out = m_owner;
        m_held      = 1;
      end
    end
  endtask

  task automatic check();
    logic [N-1:0] eg;
    logic [N-1:0] egr;
    eg  = (m_owner >= 0) ? ~(N'(1) << m_owner) : '1;
    egr = ~eg;
    chk("gate_n", gate_n, eg);
    chk("grant", grant, egr);
    chk("busy", busy, (m_owner >= 0) || (m_since < DEAD_CYC));
    chk("owner", owner, m_owner_out);
    chk("onehot", $countones(~gate_n) <= 1, 1);
    if (gate_n == '1) begin
      high_run++;
    end else begin
      if (prev_gate == '1 && seen_owner != 0) chk("dead_gap", high_run >= DEAD_CYC, 1);
      if (prev_gate != '1) chk("no_switch", gate_n == prev_gate, 1);
      high_run   = 0;
      seen_owner = 1;
    end
    prev_gate = gate_n;
  endtask

  task automatic step(input logic [N-1:0] r);
    req = r;
    @(posedge clk);
    if (rst_n) model_edge(r);
    else model_reset();
    @(negedge clk);
    check();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    check();
    rst_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int           budget;
    int           n;
    int           n_own0;
    int           first1;
    logic [N-1:0] r;

    rst_n = 1'b0;
    req   = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_gate_n", gate_n, 4'b1111);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    rst_n = 1'b1;

    // Single grant and release with dead time.
    step(4'b0001);
    chk("single_grant", gate_n, 4'b1110);
    repeat (3) step(4'b0001);
    step(4'b0000);
    chk("single_release", gate_n, 4'b1111);
    chk("single_busy_d0", busy, 1);
    step(4'b0000);
    chk("single_busy_d1", busy, 1);
    step(4'b0000);
    chk("single_idle", busy, 0);

    // Round-robin fairness with all requesters asserted.
    do_reset();
    for (int t = 0; t < 5; t++) begin
      budget = 0;
      while (grant == '0 && budget < 20) begin
        step(4'b1111);
        budget++;
      end
      chk("rr_wait", budget < 20, 1);
      chk("rr_owner", owner, t % N);
      if (t > 0) chk("rr_gap", budget, DEAD_CYC + 1);
      step(4'b1111);
      step(4'b1111);
      r = 4'b1111 & ~(N'(1) << owner);
      step(r);
      chk("rr_released", grant, 0);
    end

    // Request arriving during DEAD waits for IDLE arbitration.
    do_reset();
    step(4'b0100);
    chk("dead_owner2", gate_n, 4'b1011);
    step(4'b0100);
    step(4'b0000);
    n = 0;
    do begin
      step(4'b1000);
      n++;
    end while (gate_n[3] != 1'b0 && n < 20);
    chk("dead_req_lat", n, DEAD_CYC + 1);
    repeat (4) step(4'b0000);

    // Two requesters held constantly.
    do_reset();
    n_own0 = 0;
    first1 = -1;
    for (int s = 1; s <= 20; s++) begin
      step(4'b0011);
      if (grant == 4'b0001) n_own0++;
      if (grant == 4'b0010 && first1 < 0) first1 = s;
    end
`ifdef PMOS_ARB_TIMEOUT_EN
    chk("timeout_hold", n_own0, MAX_HOLD);
    chk("timeout_next", first1, MAX_HOLD + DEAD_CYC + 2);
`else
    chk("hold_no_timeout", n_own0, 20);
    chk("no_second_owner", first1, -1);
`endif

    // Asynchronous reset in the middle of an ON period.
    do_reset();
    step(4'b0010);
    step(4'b0010);
    chk("mid_on_gate_n", gate_n, 4'b1101);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_gate_n", gate_n, 4'b1111);
    chk("async_grant", grant, 0);
    chk("async_busy", busy, 0);
    model_reset();
    @(negedge clk);
    check();
    rst_n = 1'b1;
    step(4'b0010);
    chk("no_dead_after_rst", gate_n, 4'b1101);

    // Random traffic; requests tend to persist for several cycles.
    do_reset();
    r = '0;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) r = N'($urandom);
      if (i == 5000) do_reset();
      step(r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
